// File: rtl/adder_pkg.sv
// Shared definitions for the adder result-path blocks.
//   accf_state_t : frame accumulator FSM state
//   ADDER_SUM_W  : width of the 8-bit adder's sum output (carry included)
//   ACCF_ACC_W   : default frame accumulator width
//   ACCF_CNT_W   : default frame-length / beat-count width
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } accf_state_t;

  localparam int ADDER_SUM_W = 9;
  localparam int ACCF_ACC_W  = 16;
  localparam int ACCF_CNT_W  = 8;

endpackage

// File: rtl/adder_accum_frame_sat_add.sv
// sat_add: combinational unsigned saturating adder.
//   a   [ACC_W] : accumulator operand
//   b   [SUM_W] : narrower addend, zero-extended
//   y   [ACC_W] : a+b, clamped to all ones on carry-out
//   sat         : carry-out occurred, y was clamped
module sat_add #(
  parameter int ACC_W = 16,
  parameter int SUM_W = 9
) (
  input  logic [ACC_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [ACC_W-1:0] y,
  output logic             sat
);

  logic [ACC_W:0] wide;

  // One extra bit catches the carry; ACC_W >= SUM_W keeps the pad width >= 1.
  assign wide = {1'b0, a} + {{(ACC_W + 1 - SUM_W){1'b0}}, b};
  assign sat  = wide[ACC_W];
  assign y    = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/adder_accum_frame.sv
// adder_accum_frame: accumulates frame_len adder sums into a saturating
// total and hands the frame result to a sink over valid/ready.
//   clk, rst_n            : clock, async active-low reset
//   clear                 : sync abort, drops partial frame / pending result
//   frame_len [CNT_W]     : beats per frame (0 means 1), sampled on first beat
//   in_valid/in_ready     : input beat handshake, in_sum [SUM_W] payload
//   out_valid/out_ready   : result handshake
//   out_acc [ACC_W]       : saturated frame total
//   out_count [CNT_W]     : beats in the frame
//   out_ovf               : some add in the frame saturated
module adder_accum_frame
  import adder_pkg::*;
#(
  parameter int SUM_W = ADDER_SUM_W,
  parameter int ACC_W = ACCF_ACC_W,
  parameter int CNT_W = ACCF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  accf_state_t      state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt, cnt_inc, len_q, len_eff;
  logic             ovf, out_valid_q;
  logic [ACC_W-1:0] sum_y;
  logic             sum_sat;

  sat_add #(.ACC_W(ACC_W), .SUM_W(SUM_W)) u_sat_add (
    .a   (acc),
    .b   (in_sum),
    .y   (sum_y),
    .sat (sum_sat)
  );

  assign len_eff = (frame_len == '0) ? CNT_W'(1) : frame_len;
  assign cnt_inc = cnt + CNT_W'(1);

  // State register; out_valid is its own flop tracking entry into HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt == HOLD);
    end
  end

  // Next state; clear overrides any handshake in the same cycle.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
        ACCUM:   if (in_valid && cnt_inc == len_q) state_nxt = HOLD;
        HOLD:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: in_ready depends on state only, results come straight from regs.
  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = out_valid_q;
    out_acc   = acc;
    out_count = cnt;
    out_ovf   = ovf;
  end

  // Datapath. In IDLE/ACCUM in_ready is 1, so in_valid alone marks a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      len_q <= CNT_W'(1);
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          len_q <= len_eff;
          acc   <= {{(ACC_W - SUM_W){1'b0}}, in_sum};
          cnt   <= CNT_W'(1);
          ovf   <= 1'b0;
        end
        ACCUM: if (in_valid) begin
          acc <= sum_y;
          cnt <= cnt_inc;
          ovf <= ovf | sum_sat;
        end
        HOLD: if (out_ready) begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
